// File: rtl/fp_pkg.sv
// +----------------------------------------------------------------------------+
// | fp_pkg : shared op-codes, flag indices, FSM state type and default format. |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package fp_pkg;

   localparam int FP_EXP_DEF  = 8;
   localparam int FP_FRAC_DEF = 23;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam int FLG_NX = 0;
   localparam int FLG_UF = 1;
   localparam int FLG_OF = 2;
   localparam int FLG_DZ = 3;
   localparam int FLG_NV = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/fpu_seq.sv
// +----------------------------------------------------------------------------+
// | fpu_seq : issue/collect front-end for a combinational FP ALU with sticky    |
// |           exception flags and a completed-operation counter.               |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module fpu_seq
   import fp_pkg::*;
#(
   parameter int EXP     = FP_EXP_DEF,
   parameter int FRAC    = FP_FRAC_DEF,
   parameter int WIDTH   = EXP + FRAC + 1,
   parameter int ALU_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [1:0]       req_op,
   input  logic             req_rm,
   output logic [WIDTH-1:0] alu_op_a,
   output logic [WIDTH-1:0] alu_op_b,
   output logic [1:0]       alu_op_code,
   output logic             alu_round_mode,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [4:0]       alu_flags,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic [4:0]       rsp_flags,
   output logic [4:0]       fflags,
   input  logic             fflags_clr,
   output logic [15:0]      op_count,
   output logic             busy
);

   localparam int             LCW      = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [LCW-1:0] LAT_LOAD = LCW'(ALU_LAT - 1);

   state_t           r_state;
   logic [LCW-1:0]   r_lat_cnt;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [1:0]       r_alu_op;
   logic             r_alu_rm;
   logic [WIDTH-1:0] r_rsp_result;
   logic [4:0]       r_rsp_flags;
   logic [4:0]       r_fflags;
   logic [15:0]      r_op_count;
   logic             r_req_ready;
   logic             r_rsp_valid;
   logic             r_busy;

   logic             w_capture;
   logic [4:0]       w_fflags_next;

   assign w_capture     = (r_state == ST_EXEC) && (r_lat_cnt == '0);
   // A clear coinciding with a capture still keeps the newly captured flags.
   assign w_fflags_next = (fflags_clr ? 5'b0 : r_fflags) | (w_capture ? alu_flags : 5'b0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_lat_cnt    <= '0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_op     <= 2'b00;
         r_alu_rm     <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_flags  <= 5'b0;
         r_fflags     <= 5'b0;
         r_op_count   <= 16'd0;
         r_req_ready  <= 1'b1;
         r_rsp_valid  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_fflags <= w_fflags_next;
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_alu_a     <= req_a;
                  r_alu_b     <= req_b;
                  r_alu_op    <= req_op;
                  r_alu_rm    <= req_rm;
                  r_lat_cnt   <= LAT_LOAD;
                  r_state     <= ST_EXEC;
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
               end
            end
            ST_EXEC: begin
               if (r_lat_cnt != '0) begin
                  r_lat_cnt <= r_lat_cnt - 1'b1;
               end else begin
                  r_rsp_result <= alu_result;
                  r_rsp_flags  <= alu_flags;
                  r_state      <= ST_RESP;
                  r_rsp_valid  <= 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_op_count  <= r_op_count + 16'd1;
                  r_state     <= ST_IDLE;
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_rsp_valid <= 1'b0;
               r_req_ready <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready      = r_req_ready;
   assign rsp_valid      = r_rsp_valid;
   assign busy           = r_busy;
   assign alu_op_a       = r_alu_a;
   assign alu_op_b       = r_alu_b;
   assign alu_op_code    = r_alu_op;
   assign alu_round_mode = r_alu_rm;
   assign rsp_result     = r_rsp_result;
   assign rsp_flags      = r_rsp_flags;
   assign fflags         = r_fflags;
   assign op_count       = r_op_count;

endmodule

`default_nettype wire

// File: doc/fpu_seq.md
# fpu_seq

Sequential issue/collect front-end for the combinational floating-point ALU. It accepts one operation at a time over a valid/ready request channel and drives registered, stable operands into the ALU. It waits a fixed latency, captures result and exception flags, and returns them over a valid/ready response channel. It also keeps a sticky IEEE-754 exception-flag register (fflags) and a completed-operation counter for the surrounding datapath.

## Interface
- EXP, 8, exponent field width
- FRAC, 23, fraction field width
- WIDTH, EXP+FRAC+1, operand/result width
- ALU_LAT, 1, cycles between operands becoming stable at the ALU and the result being sampled (≥1)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_a, req_b  in  WIDTH  operands
- req_op  in  2  00 add, 01 sub, 10 mul, 11 div
- req_rm  in  1  rounding mode, passed through to the ALU
- alu_op_a, alu_op_b  out  WIDTH  registered operands to ALU
- alu_op_code  out  2  registered op
- alu_round_mode  out  1  registered rounding mode
- alu_result  in  WIDTH  ALU result
- alu_flags  in  5  ALU flags: [0] inexact, [1] underflow, [2] overflow, [3] div_by_0, [4] invalid
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  WIDTH  captured result
- rsp_flags  out  5  captured flags, same bit map
- fflags  out  5  sticky OR of all captured flags
- fflags_clr  in  1  synchronous clear of fflags
- op_count  out  16  completed responses, wraps 0xFFFF→0
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch req_a/b/op/rm into alu_* registers, load lat_cnt=ALU_LAT-1, go EXEC.
- EXEC: alu_* registers are held constant. If lat_cnt≠0, decrement lat_cnt. If lat_cnt==0, capture alu_result→rsp_result and alu_flags→rsp_flags, update fflags, go RESP.
- RESP: rsp_valid=1. rsp_result/rsp_flags are held stable until the handshake. On rsp_ready, increment op_count and go IDLE. No new request is accepted in RESP (req_ready=0).
- fflags update:
  - fflags_next = (fflags_clr ? 0 : fflags) | (capture ? alu_flags : 0).
  - Clear and capture in the same cycle: the captured flags survive.
- alu_* registers keep their last values in IDLE; they are not zeroed after completion.
- All ALU bit patterns are passed unmodified: NaN, inf and denormals are not checked.

## Timing
- Request accepted at edge T. The ALU sees operands from T+1. The result is sampled at edge T+ALU_LAT. rsp_valid is high from T+ALU_LAT through the edge where rsp_ready=1.
- ALU_LAT=1: rsp_valid one cycle after acceptance. With rsp_ready held high, throughput is one op per ALU_LAT+2 cycles.
- req_ready and rsp_valid are pure functions of state (no combinational path from req_valid or rsp_ready).
- Reset (asynchronous, any state):
  - state=IDLE.
  - alu_op_a/b=0, alu_op_code=0, alu_round_mode=0.
  - rsp_result=0, rsp_flags=0, rsp_valid=0.
  - fflags=0, op_count=0, lat_cnt=0, busy=0.
  - req_ready=1 after release.
  - An in-flight op is discarded; no response is produced and op_count is not incremented.
- op_count wrap: 0xFFFF + completion → 0x0000.

## Structure
- Shared package fp_pkg holds:
  - op-code constants OP_ADD/OP_SUB/OP_MUL/OP_DIV.
  - flag bit indices FLG_NX/FLG_UF/FLG_OF/FLG_DZ/FLG_NV.
  - the state enum.
  - the default EXP/FRAC.
- No sub-module is needed. The ALU is instantiated beside this block by the parent, not inside it.

## Test plan
- ALU_LAT=1, add 0x3F800000 + 0x40000000 (rm=0) -> rsp_valid one cycle after accept, rsp_result=0x40400000, rsp_flags=0, op_count=1.
- Div 0x3F800000 / 0x00000000 -> rsp_result=0x7F800000, rsp_flags=5'b01000, fflags=5'b01000. A following inexact mul leaves fflags=5'b01001.
- Response backpressure: rsp_ready low 5 cycles -> rsp_valid stays 1, rsp_result/flags stable, req_ready=0 throughout, second request accepted only after handshake.
- fflags_clr asserted in the capture cycle of an op returning 5'b10000 with fflags=5'b00001 -> fflags=5'b10000.
- ALU_LAT=4, rst_n pulsed low during EXEC -> all outputs at reset values immediately, no rsp_valid afterwards, op_count=0, next request completes normally 4 cycles after accept.
- op_count preset via 65535 completions -> next completion gives op_count=0.
